fxu_reservation_station: RTL and testbench

FXU_RESERVATION_STATION -- requirements
Module: fxu_reservation_station

---
 rtl/fxu_reservation_station.sv | 179 +++++++++++++++++
 tb/tb_fxu_reservation_station.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fxu_reservation_station.sv
// fxu_reservation_station: FXU reservation station with CDB wakeup and single-issue select.
// Define RS_OLDEST_FIRST_EN to select the oldest ready entry instead of the lowest-index one.
module fxu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_instr_valid,
  input  logic [TW-1:0] in_rob_idx,
  input  logic [3:0]    in_opcode,
  input  logic [7:0]    in_i,
  input  logic          in_a_valid,
  input  logic [DW-1:0] in_a_value,
  input  logic [TW-1:0] in_a_owner,
  input  logic          in_b_valid,
  input  logic [DW-1:0] in_b_value,
  input  logic [TW-1:0] in_b_owner,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_value,
  input  logic          flush,
  input  logic          issue_ready,
  output logic          issue_valid,
  output logic [TW-1:0] issue_rob_idx,
  output logic [3:0]    issue_opcode,
  output logic [7:0]    issue_i,
  output logic [DW-1:0] issue_a,
  output logic [DW-1:0] issue_b,
  output logic          full,
  output logic [3:0]    count,
  output logic          overflow
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DEPTH-1:0] busy_q, busy_d, a_valid_q, a_valid_d, b_valid_q, b_valid_d, rdy;
  logic [TW-1:0]    rob_idx_q [DEPTH], rob_idx_d [DEPTH];
  logic [TW-1:0]    a_owner_q [DEPTH], a_owner_d [DEPTH];
  logic [TW-1:0]    b_owner_q [DEPTH], b_owner_d [DEPTH];
  logic [3:0]       opcode_q  [DEPTH], opcode_d  [DEPTH];
  logic [7:0]       imm_q     [DEPTH], imm_d     [DEPTH];
  logic [DW-1:0]    a_value_q [DEPTH], a_value_d [DEPTH];
  logic [DW-1:0]    b_value_q [DEPTH], b_value_d [DEPTH];
  logic [3:0]       count_q, count_d;
  logic             overflow_q, overflow_d, hold_q, hold_d;
  logic [IW-1:0]    hold_idx_q, hold_idx_d, pick_idx, sel_idx, free_idx;
  logic             found, free_got, fire, accept;
`ifdef RS_OLDEST_FIRST_EN
  logic [IW-1:0]    age_q [DEPTH], age_d [DEPTH];
`endif
  always_comb begin
    rdy = busy_q & a_valid_q & b_valid_q;
    found = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_OLDEST_FIRST_EN
      if (rdy[i] && (!found || age_q[i] < age_q[pick_idx])) begin
`else
      if (rdy[i] && !found) begin
`endif
        found = 1'b1;
        pick_idx = IW'(i);
      end
    end
    // A stalled offer stays locked so later wakeups cannot change it under the FXU
    sel_idx = hold_q ? hold_idx_q : pick_idx;
    free_got = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_got) begin
        free_got = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
  assign issue_valid   = found;
  assign issue_rob_idx = found ? rob_idx_q[sel_idx] : '0;
  assign issue_opcode  = found ? opcode_q[sel_idx]  : '0;
  assign issue_i       = found ? imm_q[sel_idx]     : '0;
  assign issue_a       = found ? a_value_q[sel_idx] : '0;
  assign issue_b       = found ? b_value_q[sel_idx] : '0;
  assign full          = count_q == 4'(DEPTH);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign fire          = found & issue_ready;
  assign accept        = in_instr_valid & ~full;
  always_comb begin
    busy_d = busy_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    rob_idx_d = rob_idx_q;
    a_owner_d = a_owner_q;
    b_owner_d = b_owner_q;
    opcode_d = opcode_q;
    imm_d = imm_q;
    a_value_d = a_value_q;
    b_value_d = b_value_q;
`ifdef RS_OLDEST_FIRST_EN
    age_d = age_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_valid && !a_valid_q[i] && a_owner_q[i] == cdb_tag) begin
        a_valid_d[i] = 1'b1;
        a_value_d[i] = cdb_value;
      end
      if (busy_q[i] && cdb_valid && !b_valid_q[i] && b_owner_q[i] == cdb_tag) begin
        b_valid_d[i] = 1'b1;
        b_value_d[i] = cdb_value;
      end
`ifdef RS_OLDEST_FIRST_EN
      if (fire && busy_q[i] && age_q[i] > age_q[sel_idx]) age_d[i] = age_q[i] - 1'b1;
`endif
    end
    if (fire) busy_d[sel_idx] = 1'b0;
    if (accept) begin
      busy_d[free_idx] = 1'b1;
      rob_idx_d[free_idx] = in_rob_idx;
      opcode_d[free_idx] = in_opcode;
      imm_d[free_idx] = in_i;
      a_owner_d[free_idx] = in_a_owner;
      b_owner_d[free_idx] = in_b_owner;
      a_valid_d[free_idx] = in_a_valid | (cdb_valid && in_a_owner == cdb_tag);
      b_valid_d[free_idx] = in_b_valid | (cdb_valid && in_b_owner == cdb_tag);
      a_value_d[free_idx] = in_a_valid ? in_a_value : cdb_value;
      b_value_d[free_idx] = in_b_valid ? in_b_value : cdb_value;
`ifdef RS_OLDEST_FIRST_EN
      age_d[free_idx] = IW'(count_q - 4'(fire));
`endif
    end
    count_d = count_q + 4'(accept) - 4'(fire);
    overflow_d = overflow_q | (in_instr_valid & full);
    hold_d = found & ~issue_ready;
    hold_idx_d = sel_idx;
    if (flush) begin
      busy_d = '0;
      count_d = '0;
      hold_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      a_valid_q <= '0;
      b_valid_q <= '0;
      rob_idx_q <= '{default: '0};
      a_owner_q <= '{default: '0};
      b_owner_q <= '{default: '0};
      opcode_q <= '{default: '0};
      imm_q <= '{default: '0};
      a_value_q <= '{default: '0};
      b_value_q <= '{default: '0};
      count_q <= '0;
      overflow_q <= 1'b0;
      hold_q <= 1'b0;
      hold_idx_q <= '0;
`ifdef RS_OLDEST_FIRST_EN
      age_q <= '{default: '0};
`endif
    end else begin
      busy_q <= busy_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      rob_idx_q <= rob_idx_d;
      a_owner_q <= a_owner_d;
      b_owner_q <= b_owner_d;
      opcode_q <= opcode_d;
      imm_q <= imm_d;
      a_value_q <= a_value_d;
      b_value_q <= b_value_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      hold_q <= hold_d;
      hold_idx_q <= hold_idx_d;
`ifdef RS_OLDEST_FIRST_EN
      age_q <= age_d;
`endif
    end
  end
endmodule

// File: tb/tb_fxu_reservation_station.sv
// tb_fxu_reservation_station: directed vector table plus hand sequences for flush, ordering and reset.
module tb_fxu_reservation_station;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_instr_valid, in_a_valid, in_b_valid, cdb_valid, flush, issue_ready;
  logic [3:0] in_rob_idx, in_opcode, in_a_owner, in_b_owner, cdb_tag;
  logic [7:0] in_i;
  logic [15:0] in_a_value, in_b_value, cdb_value;
  logic issue_valid, full, overflow;
  logic [3:0] issue_rob_idx, issue_opcode, count;
  logic [7:0] issue_i;
  logic [15:0] issue_a, issue_b;
  int n_cmp = 0, n_bad = 0;

  fxu_reservation_station dut (
    .clk(clk), .rst_n(rst_n), .in_instr_valid(in_instr_valid), .in_rob_idx(in_rob_idx),
    .in_opcode(in_opcode), .in_i(in_i), .in_a_valid(in_a_valid), .in_a_value(in_a_value),
    .in_a_owner(in_a_owner), .in_b_valid(in_b_valid), .in_b_value(in_b_value),
    .in_b_owner(in_b_owner), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_rob_idx(issue_rob_idx), .issue_opcode(issue_opcode), .issue_i(issue_i),
    .issue_a(issue_a), .issue_b(issue_b), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dv; logic [3:0] rob; logic av; logic [15:0] a; logic [3:0] ao;
    logic bv; logic [15:0] b; logic [3:0] bo; logic cv; logic [3:0] ct; logic [15:0] cval;
    logic fl; logic ir;
    logic ev; logic [3:0] erob; logic [15:0] ea; logic [15:0] eb; logic ef; logic [3:0] ec; logic eo;
  } vec_t;

  function automatic vec_t mkv(input int dv, rob, av, a, ao, bv, b, bo, cv, ct, cval, fl, ir,
                               input int ev, erob, ea, eb, ef, ec, eo);
    vec_t v;
    v.dv = dv[0]; v.rob = rob[3:0]; v.av = av[0]; v.a = a[15:0]; v.ao = ao[3:0];
    v.bv = bv[0]; v.b = b[15:0]; v.bo = bo[3:0]; v.cv = cv[0]; v.ct = ct[3:0]; v.cval = cval[15:0];
    v.fl = fl[0]; v.ir = ir[0];
    v.ev = ev[0]; v.erob = erob[3:0]; v.ea = ea[15:0]; v.eb = eb[15:0]; v.ef = ef[0]; v.ec = ec[3:0]; v.eo = eo[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    logic [3:0] eop;
    logic [7:0] eimm;
    eop = v.ev ? 4'(v.erob + 4'd1) : 4'd0;
    eimm = v.ev ? {v.erob, v.erob} : 8'd0;
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'(v.ev));
    chk({tag, " issue_rob_idx"}, 32'(issue_rob_idx), 32'(v.ev ? v.erob : 4'd0));
    chk({tag, " issue_opcode"}, 32'(issue_opcode), 32'(eop));
    chk({tag, " issue_i"}, 32'(issue_i), 32'(eimm));
    chk({tag, " issue_a"}, 32'(issue_a), 32'(v.ev ? v.ea : 16'd0));
    chk({tag, " issue_b"}, 32'(issue_b), 32'(v.ev ? v.eb : 16'd0));
    chk({tag, " full"}, 32'(full), 32'(v.ef));
    chk({tag, " count"}, 32'(count), 32'(v.ec));
    chk({tag, " overflow"}, 32'(overflow), 32'(v.eo));
  endtask

  task automatic idle();
    in_instr_valid = 0; in_rob_idx = 0; in_opcode = 0; in_i = 0;
    in_a_valid = 0; in_a_value = 0; in_a_owner = 0; in_b_valid = 0; in_b_value = 0; in_b_owner = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; flush = 0; issue_ready = 0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    in_instr_valid = v.dv; in_rob_idx = v.rob; in_opcode = 4'(v.rob + 4'd1); in_i = {v.rob, v.rob};
    in_a_valid = v.av; in_a_value = v.a; in_a_owner = v.ao;
    in_b_valid = v.bv; in_b_value = v.b; in_b_owner = v.bo;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval; flush = v.fl; issue_ready = v.ir;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  vec_t vecs [19];
  int ord_first, ord_second;

  initial begin
    //                 dv rob av a      ao bv b      bo cv ct cval    fl ir   ev rob a      b      f  c  o
    vecs[0]  = mkv(1, 3, 1, 'h0010, 0, 1, 'h0020, 0, 0, 0, 0,      0, 1,  1, 3, 'h0010, 'h0020, 0, 1, 0);
    vecs[1]  = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 1,  0, 0, 0,      0,      0, 0, 0);
    vecs[2]  = mkv(1, 1, 1, 'h0001, 0, 0, 0,      5, 0, 0, 0,      0, 1,  0, 0, 0,      0,      0, 1, 0);
    vecs[3]  = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 0,  0, 0, 0,      0,      0, 1, 0);
    vecs[4]  = mkv(0, 0, 0, 0,      0, 0, 0,      0, 1, 5, 'hBEEF, 0, 0,  1, 1, 'h0001, 'hBEEF, 0, 1, 0);
    vecs[5]  = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 1,  0, 0, 0,      0,      0, 0, 0);
    vecs[6]  = mkv(1, 2, 0, 0,      7, 1, 'h0002, 0, 1, 7, 'h1234, 0, 0,  1, 2, 'h1234, 'h0002, 0, 1, 0);
    vecs[7]  = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 1,  0, 0, 0,      0,      0, 0, 0);
    vecs[8]  = mkv(1, 4, 0, 0,      6, 1, 'h0044, 0, 0, 0, 0,      0, 0,  0, 0, 0,      0,      0, 1, 0);
    vecs[9]  = mkv(0, 0, 0, 0,      0, 0, 0,      0, 1, 8, 'hFFFF, 0, 0,  0, 0, 0,      0,      0, 1, 0);
    vecs[10] = mkv(1, 5, 1, 'h0050, 0, 1, 'h0051, 0, 0, 0, 0,      0, 0,  1, 5, 'h0050, 'h0051, 0, 2, 0);
    vecs[11] = mkv(1, 6, 1, 'h0060, 0, 1, 'h0061, 0, 0, 0, 0,      0, 0,  1, 5, 'h0050, 'h0051, 0, 3, 0);
    vecs[12] = mkv(1, 7, 1, 'h0070, 0, 1, 'h0071, 0, 0, 0, 0,      0, 0,  1, 5, 'h0050, 'h0051, 1, 4, 0);
    vecs[13] = mkv(1, 8, 1, 'h0080, 0, 1, 'h0081, 0, 0, 0, 0,      0, 0,  1, 5, 'h0050, 'h0051, 1, 4, 1);
    vecs[14] = mkv(0, 0, 0, 0,      0, 0, 0,      0, 1, 6, 'h0066, 0, 0,  1, 5, 'h0050, 'h0051, 1, 4, 1);
    vecs[15] = mkv(1, 9, 1, 'h0090, 0, 1, 'h0091, 0, 0, 0, 0,      0, 1,  1, 4, 'h0066, 'h0044, 0, 3, 1);
    vecs[16] = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 1,  1, 6, 'h0060, 'h0061, 0, 2, 1);
    vecs[17] = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 1,  1, 7, 'h0070, 'h0071, 0, 1, 1);
    vecs[18] = mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 1,  0, 0, 0,      0,      0, 0, 1);
    idle();
    repeat (2) @(negedge clk);
    check_outs("reset", mkv(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    rst_n = 1'b1;
    for (int k = 0; k < 19; k++) apply($sformatf("vec%0d", k), vecs[k]);

    // Entry 2 becomes busy before entry 0; both wake on the same broadcast
    apply("ord1", mkv(1, 10, 1, 'h00A0, 0, 1, 'h00A1, 0, 0, 0, 0, 0, 0,  1, 10, 'h00A0, 'h00A1, 0, 1, 1));
    apply("ord2", mkv(1, 11, 1, 'h00B0, 0, 1, 'h00B1, 0, 0, 0, 0, 0, 0,  1, 10, 'h00A0, 'h00A1, 0, 2, 1));
    apply("ord3", mkv(1, 12, 0, 0,      9, 1, 'h00C1, 0, 0, 0, 0, 0, 0,  1, 10, 'h00A0, 'h00A1, 0, 3, 1));
    apply("ord4", mkv(0, 0,  0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 1,  1, 11, 'h00B0, 'h00B1, 0, 2, 1));
    apply("ord5", mkv(0, 0,  0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 1,  0, 0,  0,      0,      0, 1, 1));
    apply("ord6", mkv(1, 13, 0, 0,      9, 1, 'h00D1, 0, 0, 0, 0, 0, 0,  0, 0,  0,      0,      0, 2, 1));
`ifdef RS_OLDEST_FIRST_EN
    ord_first = 12; ord_second = 13;
`else
    ord_first = 13; ord_second = 12;
`endif
    apply("ord7", mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h0999, 0, 0,  1, ord_first, 'h0999, ord_first == 12 ? 'h00C1 : 'h00D1, 0, 2, 1));
    apply("ord8", mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1,  1, ord_second, 'h0999, ord_second == 12 ? 'h00C1 : 'h00D1, 0, 1, 1));
    apply("ord9", mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1,  0, 0, 0, 0, 0, 0, 1));

    // Flush beats a simultaneous dispatch and issue handshake
    apply("fl1", mkv(1, 1, 1, 'h0101, 0, 1, 'h0102, 0, 0, 0, 0, 0, 0,  1, 1, 'h0101, 'h0102, 0, 1, 1));
    apply("fl2", mkv(1, 2, 1, 'h0201, 0, 1, 'h0202, 0, 0, 0, 0, 0, 0,  1, 1, 'h0101, 'h0102, 0, 2, 1));
    apply("fl3", mkv(1, 3, 1, 'h0301, 0, 1, 'h0302, 0, 0, 0, 0, 0, 0,  1, 1, 'h0101, 'h0102, 0, 3, 1));
    apply("fl4", mkv(1, 4, 1, 'h0401, 0, 1, 'h0402, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1));
    apply("fl5", mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1));

    // Asynchronous reset in the middle of a cycle with live entries
    apply("rs1", mkv(1, 5, 1, 'h0505, 0, 1, 'h0506, 0, 0, 0, 0, 0, 0,  1, 5, 'h0505, 'h0506, 0, 1, 1));
    apply("rs2", mkv(1, 6, 1, 'h0605, 0, 1, 'h0606, 0, 0, 0, 0, 0, 0,  1, 5, 'h0505, 'h0506, 0, 2, 1));
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check_outs("rs_async", mkv(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    apply("rs3", mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 1,  0, 0, 0,      0,      0, 0, 0));
    apply("rs4", mkv(1, 7, 1, 'h0777, 0, 1, 'h0778, 0, 0, 0, 0, 0, 0,  1, 7, 'h0777, 'h0778, 0, 1, 0));
    apply("rs5", mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 1,  0, 0, 0,      0,      0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
